// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver: synchronizes the PS/2 lines, deframes 11-bit scan codes and queues them in a FIFO.
// Optional KBD_PARITY_CHK_EN: when defined, frames with bad odd parity are rejected.
`ifndef KbWidth
`define KbWidth 8
`endif

module ps2_kbd #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  input  logic                 sig_rd_kb,
  output logic [`KbWidth-1:0]  kb_rdata,
  output logic                 kb_ready,
  output logic                 overflow,
  output logic [7:0]           err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
`ifdef KBD_PARITY_CHK_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e                state_q, state_d;
  logic                  clk_s1_q, clk_s2_q, clk_s3_q, dat_s1_q, dat_s2_q;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  par_q, par_d, stop_q, stop_d;
  logic [15:0]           idle_q, idle_d;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q;
  logic [7:0]            err_q;
  logic                  ovf_q;
  logic [`KbWidth-1:0]   mem_q [FIFO_DEPTH];

  logic fall, timeout_hit, frame_ok, push, pop, err_inc;

  assign fall        = clk_s3_q & ~clk_s2_q;
  assign timeout_hit = (state_q == SHIFT) && !fall && (idle_q == TIMEOUT - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      clk_s3_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      stop_q    <= 1'b0;
      idle_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_s1_q  <= ps2_clk;
      clk_s2_q  <= clk_s1_q;
      clk_s3_q  <= clk_s2_q;
      dat_s1_q  <= ps2_data;
      dat_s2_q  <= dat_s1_q;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      stop_q    <= stop_d;
      idle_q    <= idle_d;
      if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
      if (push && pop) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end else if (push) begin
        if (count_q == FULL_CNT) begin
          ovf_q <= 1'b1;
        end else begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
          count_q  <= count_q + (AW+1)'(1);
        end
      end else if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q  <= count_q - (AW+1)'(1);
      end
    end
  end

  // Storage needs no reset: an empty count masks stale entries.
  always_ff @(posedge clk) begin
    if (!rst && push && (pop || count_q != FULL_CNT)) mem_q[wr_ptr_q] <= shift_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall && !dat_s2_q) state_d = SHIFT;
      SHIFT:   if (fall && bit_cnt_q == 4'd10) state_d = DONE;
               else if (timeout_hit) state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    stop_d    = stop_q;
    idle_d    = '0;
    frame_ok  = stop_q & ((^{shift_q, par_q}) | ~PAR_EN);
    push      = (state_q == DONE) && frame_ok;
    err_inc   = ((state_q == DONE) && !frame_ok) || timeout_hit;
    pop       = sig_rd_kb && kb_ready;
    case (state_q)
      IDLE: bit_cnt_d = (fall && !dat_s2_q) ? 4'd1 : 4'd0;
      SHIFT: begin
        if (fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q <= 4'd8)       shift_d = {dat_s2_q, shift_q[7:1]};
          else if (bit_cnt_q == 4'd9)  par_d   = dat_s2_q;
          else                         stop_d  = dat_s2_q;
        end else if (timeout_hit) begin
          bit_cnt_d = 4'd0;
        end else begin
          idle_d = idle_q + 16'd1;
        end
      end
      default: bit_cnt_d = 4'd0;
    endcase
  end

  assign kb_ready = (count_q != '0);
  assign kb_rdata = kb_ready ? mem_q[rd_ptr_q] : '0;
  assign overflow = ovf_q;
  assign err_cnt  = err_q;

endmodule
